// File: rtl/fetch_queue_stage_if.sv
// Bundle between the fetch queue stage and its neighbours: the hazard controls,
// the redirect from MEM, the instruction memory port and the IF/ID head.
// Handshake at IF/ID: the head transfers on a cycle with out_valid=1 and stall=0.
// While stall=1 the out_* fields hold their values.
interface fetch_queue_stage_if #(
   parameter int data_width    = 32,
   parameter int address_width = 12
);
   logic                     stall;
   logic                     flush;
   logic                     pc_src;
   logic [address_width-1:0] branch_target;
   logic                     imem_req;
   logic [address_width-1:0] imem_addr;
   logic [data_width-1:0]    imem_rdata;
   logic                     out_valid;
   logic [data_width-1:0]    out_instruction;
   logic [address_width-1:0] out_pc;
   logic [address_width-1:0] out_pc_plus_4;

   modport master (
      input  stall, flush, pc_src, branch_target, imem_rdata,
      output imem_req, imem_addr, out_valid, out_instruction, out_pc, out_pc_plus_4
   );

   modport slave (
      output stall, flush, pc_src, branch_target, imem_rdata,
      input  imem_req, imem_addr, out_valid, out_instruction, out_pc, out_pc_plus_4
   );
endinterface

// File: rtl/fetch_queue_stage.sv
// Instruction fetch stage with a small PC-tagged instruction queue between a
// one-cycle synchronous instruction memory and the IF/ID boundary.
module fetch_queue_stage #(
   parameter int                       data_width    = 32,
   parameter int                       address_width = 12,
   parameter int                       queue_depth   = 4,
   parameter logic [address_width-1:0] reset_pc      = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   fetch_queue_stage_if.master  bus
);
   localparam int ptr_w = $clog2(queue_depth);
   localparam int cnt_w = ptr_w + 1;

   typedef logic [address_width-1:0] addr_t;
   typedef logic [data_width-1:0]    data_t;

   addr_t            fetch_pc_q, fetch_pc_d;
   addr_t            q_pc_q    [queue_depth];
   addr_t            q_pc_d    [queue_depth];
   data_t            q_instr_q [queue_depth];
   data_t            q_instr_d [queue_depth];
   logic [ptr_w-1:0] rd_ptr_q, rd_ptr_d;
   logic [ptr_w-1:0] wr_ptr_q, wr_ptr_d;
   logic [cnt_w-1:0] count_q, count_d;
   logic             inflight_q, inflight_d;
   addr_t            inflight_pc_q, inflight_pc_d;

   logic             kill;
   logic             req;
   logic             push;
   logic             pop;
   logic             head_valid;
   logic [cnt_w:0]   occupancy;

   // Credit uses registered occupancy only, so a same-cycle pop never frees a slot.
   always_comb begin
      kill       = bus.pc_src | bus.flush;
      head_valid = (count_q != '0);
      occupancy  = {1'b0, count_q} + {{cnt_w{1'b0}}, inflight_q};
      req        = !reset && !kill && (occupancy < (cnt_w + 1)'(queue_depth));
      push       = inflight_q && !kill;
      pop        = head_valid && !bus.stall && !kill;
   end

   assign bus.imem_req        = req;
   assign bus.imem_addr       = fetch_pc_q;
   assign bus.out_valid       = head_valid && !reset;
   assign bus.out_instruction = reset ? '0 : q_instr_q[rd_ptr_q];
   assign bus.out_pc          = reset ? '0 : q_pc_q[rd_ptr_q];
   assign bus.out_pc_plus_4   = reset ? '0 : q_pc_q[rd_ptr_q] + addr_t'(4);

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      q_pc_d        = q_pc_q;
      q_instr_d     = q_instr_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      inflight_d    = inflight_q;
      inflight_pc_d = inflight_pc_q;

      // Replay restarts at the oldest PC decode has not yet consumed.
      if (bus.pc_src) begin
         fetch_pc_d = bus.branch_target;
      end else if (bus.flush) begin
         if (head_valid) begin
            fetch_pc_d = q_pc_q[rd_ptr_q];
         end else if (inflight_q) begin
            fetch_pc_d = inflight_pc_q;
         end
      end

      if (kill) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         inflight_d = 1'b0;
      end else begin
         if (push) begin
            q_pc_d[wr_ptr_q]    = inflight_pc_q;
            q_instr_d[wr_ptr_q] = bus.imem_rdata;
            wr_ptr_d            = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         count_d    = count_q + cnt_w'(push) - cnt_w'(pop);
         inflight_d = req;
         if (req) begin
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + addr_t'(4);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q    <= reset_pc;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   // Queue payload needs no reset; it is only observed behind count.
   always_ff @(posedge clk) begin
      q_pc_q    <= q_pc_d;
      q_instr_q <= q_instr_d;
   end
endmodule

// File: tb/tb_fetch_queue_stage.sv
// Bench for fetch_queue_stage: directed scenarios plus a randomized phase, all
// checked against a queue-of-PCs reference model of the fetch behaviour.
module tb_fetch_queue_stage;
   localparam int          DW    = 32;
   localparam int          AW    = 12;
   localparam int          DEPTH = 4;
   localparam logic [AW-1:0] RPC = 12'hFF8;

   logic clk;
   logic reset;

   fetch_queue_stage_if #(.data_width(DW), .address_width(AW)) bus ();

   fetch_queue_stage #(
      .data_width(DW), .address_width(AW), .queue_depth(DEPTH), .reset_pc(RPC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] a);
      return {a, 8'hA5, ~a};
   endfunction

   // instruction memory: one-cycle synchronous read
   always @(posedge clk) begin
      if (bus.imem_req) bus.imem_rdata <= instr_of(bus.imem_addr);
   end

   // reference model: PCs expected at IF/ID in order, plus the fetch front end
   logic [AW-1:0] exp_q[$];
   logic [AW-1:0] m_fpc;
   logic          m_inflight;
   logic [AW-1:0] m_ipc;
   int checks;
   int errors;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_req();
      return !reset && !bus.pc_src && !bus.flush &&
             (exp_q.size() + int'(m_inflight) < DEPTH);
   endfunction

   // settle after the input change, then compare every output against the model
   task automatic settle();
      logic          m_valid;
      logic          m_req;
      logic [AW-1:0] p4;
      #1;
      m_valid = !reset && (exp_q.size() != 0);
      m_req   = model_req();
      chk("out_valid", bus.out_valid, m_valid);
      chk("imem_req", bus.imem_req, m_req);
      if (m_req) chk("imem_addr", bus.imem_addr, m_fpc);
      if (reset) chk("reset_out_pc", bus.out_pc, 0);
      if (m_valid) begin
         p4 = exp_q[0] + 12'd4;
         chk("out_pc", bus.out_pc, exp_q[0]);
         chk("out_pc_plus_4", bus.out_pc_plus_4, p4);
         chk("out_instruction", bus.out_instruction, instr_of(exp_q[0]));
      end
   endtask

   // advance one clock and apply the fetch rules to the model
   task automatic adv();
      logic          r;
      logic [AW-1:0] np;
      r = model_req();
      @(posedge clk);
      if (reset) begin
         exp_q.delete();
         m_fpc      = RPC;
         m_inflight = 1'b0;
      end else if (bus.pc_src || bus.flush) begin
         if (bus.pc_src)            np = bus.branch_target;
         else if (exp_q.size() > 0) np = exp_q[0];
         else if (m_inflight)       np = m_ipc;
         else                       np = m_fpc;
         exp_q.delete();
         m_inflight = 1'b0;
         m_fpc      = np;
      end else begin
         if (exp_q.size() > 0 && !bus.stall) void'(exp_q.pop_front());
         if (m_inflight) exp_q.push_back(m_ipc);
         m_inflight = r;
         if (r) begin
            m_ipc = m_fpc;
            m_fpc = m_fpc + 12'd4;
         end
      end
      @(negedge clk);
   endtask

   task automatic step();
      settle();
      adv();
   endtask

   task automatic drive(input logic s, input logic f, input logic p, input logic [AW-1:0] t);
      bus.stall         = s;
      bus.flush         = f;
      bus.pc_src        = p;
      bus.branch_target = t;
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      m_fpc      = RPC;
      m_inflight = 1'b0;
      m_ipc      = '0;
      reset      = 1'b1;
      drive(1'b0, 1'b0, 1'b0, '0);
      @(negedge clk);

      // reset held, then release: FF8, FFC, 000 with wrap
      step();
      step();
      reset = 1'b0;
      settle(); chk("c0_req", bus.imem_req, 1); chk("c0_addr", bus.imem_addr, 12'hFF8); adv();
      settle(); chk("c1_valid", bus.out_valid, 0); adv();
      settle(); chk("c2_valid", bus.out_valid, 1); chk("c2_pc", bus.out_pc, 12'hFF8); adv();
      settle(); chk("c3_pc", bus.out_pc, 12'hFFC); chk("c3_pc4", bus.out_pc_plus_4, 12'h000); adv();
      settle(); chk("c4_pc", bus.out_pc, 12'h000); adv();
      settle(); chk("c5_pc", bus.out_pc, 12'h004); adv();
      settle(); chk("c6_pc", bus.out_pc, 12'h008); adv();
      settle(); chk("c7_pc", bus.out_pc, 12'h00C); adv();

      // stall six cycles: queue fills and requests stop
      drive(1'b1, 1'b0, 1'b0, '0);
      settle(); chk("stall_head", bus.out_pc, 12'h010); adv();
      repeat (4) step();
      settle(); chk("stall_req_drop", bus.imem_req, 0); chk("stall_hold", bus.out_pc, 12'h010); adv();
      drive(1'b0, 1'b0, 1'b0, '0);
      settle(); chk("release_pc0", bus.out_pc, 12'h010); adv();
      settle(); chk("release_pc1", bus.out_pc, 12'h014); adv();
      repeat (4) step();

      // one stall cycle leaves 3 queued + 1 in flight, then redirect to 0x100
      drive(1'b1, 1'b0, 1'b0, '0);
      step();
      drive(1'b0, 1'b0, 1'b1, 12'h100);
      settle(); chk("redir_req", bus.imem_req, 0); adv();
      drive(1'b0, 1'b0, 1'b0, '0);
      settle(); chk("redir_r1_valid", bus.out_valid, 0); chk("redir_r1_addr", bus.imem_addr, 12'h100); adv();
      settle(); chk("redir_r2_valid", bus.out_valid, 0); adv();
      settle(); chk("redir_r3_pc", bus.out_pc, 12'h100); chk("redir_r3_valid", bus.out_valid, 1); adv();
      settle(); chk("redir_r4_pc", bus.out_pc, 12'h104); adv();

      // build head 0x20 with count 2 under stall, then replay
      drive(1'b1, 1'b0, 1'b1, 12'h020);
      step();
      drive(1'b1, 1'b0, 1'b0, '0);
      repeat (3) step();
      drive(1'b0, 1'b1, 1'b0, '0);
      settle(); chk("flush_head", bus.out_pc, 12'h020); adv();
      drive(1'b0, 1'b0, 1'b0, '0);
      settle(); chk("flush_addr", bus.imem_addr, 12'h020); chk("flush_valid", bus.out_valid, 0); adv();
      step();
      settle(); chk("flush_pc0", bus.out_pc, 12'h020); adv();
      settle(); chk("flush_pc1", bus.out_pc, 12'h024); adv();

      // redirect and replay together: redirect wins
      drive(1'b0, 1'b1, 1'b1, 12'h040);
      step();
      drive(1'b0, 1'b0, 1'b0, '0);
      settle(); chk("both_addr", bus.imem_addr, 12'h040); chk("both_req", bus.imem_req, 1); adv();
      repeat (4) step();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 59) == 0);
         drive($urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
               $urandom_range(0, 19) == 0, {10'($urandom_range(0, 1023)), 2'b00});
         step();
      end

      // mid-stream reset restarts at reset_pc
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, '0);
      repeat (6) step();
      reset = 1'b1;
      settle(); chk("mid_reset_valid", bus.out_valid, 0); chk("mid_reset_req", bus.imem_req, 0); adv();
      reset = 1'b0;
      settle(); chk("post_reset_valid", bus.out_valid, 0); chk("post_reset_addr", bus.imem_addr, 12'hFF8); adv();
      step();
      settle(); chk("post_reset_pc", bus.out_pc, 12'hFF8); adv();
      repeat (3) step();

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
Parametrised successor to the single-PC fetch stage. It decouples instruction fetch from decode through a small instruction queue. It drives a synchronous-read instruction memory with one-cycle latency, tags each word with its PC, and presents queued {pc, pc+4, instruction} to the IF/ID boundary. It supports branch redirect (pc_src), replay flush and decode stall without losing or duplicating instructions.

Parameters:
data_width, 32, instruction word width
address_width, 12, byte-address width of PC; all PC arithmetic is modulo 2^address_width
queue_depth, 4, instruction queue entries (power of two, >=2)
reset_pc, 0, PC fetched first after reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state
stall  input  1  from Hazard Unit; 1 = decode not accepting
flush  input  1  from Hazard Unit; replay: discard queued/in-flight work, refetch oldest unconsumed PC
pc_src  input  1  from MEM; 1 = branch taken, redirect to branch_target
branch_target  input  address_width  redirect PC
imem_req  output  1  read request this cycle
imem_addr  output  address_width  byte address of request (= fetch_pc)
imem_rdata  input  data_width  word for request issued previous cycle
out_valid  output  1  head entry valid at IF/ID
out_instruction  output  data_width  head instruction
out_pc  output  address_width  head PC
out_pc_plus_4  output  address_width  out_pc + 4, wraps

Behaviour:
- State: fetch_pc; queue of queue_depth {pc, instr}; count (0..queue_depth); inflight flag plus inflight_pc.
- Reset (any cycle, including mid-operation): fetch_pc=reset_pc, count=0, inflight=0. During reset cycle imem_req=0 and out_valid=0; out_* data are don't-care but driven 0.
- Request: imem_req = !reset && !pc_src && !flush && (count + inflight < queue_depth), using registered count and inflight only. Same-cycle pop does not add credit. On request, inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (wraps). With no request, inflight<=0.
- Response: when inflight=1 and no kill this cycle, {inflight_pc, imem_rdata} is written at tail. It is visible at the head no earlier than the next cycle; there is no bypass.
- Pop: out_valid = (count!=0). Head is removed when out_valid && !stall. Push and pop in the same cycle leave count unchanged. The credit rule prevents push when full. Pop when empty is a no-op.
- Latency: after reset is released, the cycle-0 request for reset_pc gives a response in cycle 1 and out_valid=1 with out_pc=reset_pc in cycle 2. Steady state with stall=0 sustains one instruction per cycle.
- Redirect (pc_src=1), highest priority over flush: queue cleared, in-flight response discarded (kill), fetch_pc<=branch_target, no request. Cycle R+1 requests branch_target, and out_valid=1 for branch_target in R+3. out_valid=0 in R+1 and R+2.
- Replay (flush=1, pc_src=0): kill queue and in-flight, no request. fetch_pc<= head pc if count!=0, else inflight_pc if inflight, else unchanged. Refetch resumes the next cycle.
- stall has no effect on redirect or replay; those act regardless of stall.
- The PC sequence crossing 2^address_width-4 wraps to 0 silently.
- Instructions leave in strictly program order. No instruction is duplicated or dropped except by kill.

Test Plan:
- Reset release, reset_pc=0, stall=0: imem_req each cycle with addr 0,4,8,…; out_valid rises in cycle 2, then out_pc 0,4,8,12 on consecutive cycles; out_pc_plus_4 = out_pc+4.
- stall=1 for 6 cycles from steady state, depth 4: queue fills, imem_req drops once count+inflight=4, and out_pc is held. Release: out_pc continues with no gap or repeat.
- pc_src=1, branch_target=0x100 while queue holds 3 entries and one is in flight: out_valid=0 for 2 cycles, then out_pc=0x100, 0x104. No stale PC appears.
- flush=1 with head pc=0x20 and count=2: queue emptied, next imem_addr=0x20, out_pc resumes 0x20, 0x24.
- pc_src and flush in the same cycle with branch_target=0x40: redirect wins, next imem_addr=0x40.
- address_width=12, reset_pc=0xFF8: out_pc sequence 0xFF8, 0xFFC, 0x000; out_pc_plus_4 at 0xFFC is 0x000. Also assert reset mid-stream: out_valid=0 the next cycle and fetch restarts at reset_pc.
